spi_reg_responder: RTL and testbench
====================================

Name: spi_reg_responder

Overview:
- SPI peripheral (responder) for the Nios SPI0 master. It is the device-side counterpart of the keyboard host link.
- Models a MAX3421E-style register interface. The command byte carries a register address and a direction bit; data bytes follow.
- Gives the fabric a 32x8 register file that the master reads and writes, plus a local read port and a write-notification strobe.
- Used in simulation and on a second board to stand in for the USB host chip.

Parameters:
ADDR_W, 5, register address width (32 registers)
DATA_W, 8, register and SPI byte width (fixed 8; other values unsupported)

Ports:
Clk  input  1  system clock (50 MHz)
Reset  input  1  asynchronous, active-high reset
SCLK  input  1  SPI clock from master (mode 0, CPOL=0, CPHA=0), asynchronous to Clk
SS_n  input  1  SPI chip select, active low, asynchronous
MOSI  input  1  master-out data, asynchronous
MISO  output  1  responder-out data
MISO_OE  output  1  MISO drive enable; the top level tri-states the pin when low
STATUS  input  8  status byte shifted out during every command byte
rd_addr  input  5  local read address
rd_data  output  8  local read data
wr_strobe  output  1  one-Clk pulse per SPI-written byte
wr_addr  output  5  address of the byte just written
wr_data  output  8  value of the byte just written
busy  output  1  synchronized SS_n is low

Behaviour:
- Reset values:
  - All 32 registers = 0x00.
  - MISO=0, MISO_OE=0, rd_data=0x00, wr_strobe=0, wr_addr=0, wr_data=0x00, busy=0.
  - State = IDLE.
- Input synchronization:
  - SCLK, SS_n and MOSI each pass through a 2-flop synchronizer.
  - SCLK rising and falling edges are detected on the synchronized value.
  - Clk must be at least 8x SCLK; slower Clk is unsupported.
- States: IDLE, CMD, DATA.
- Synchronized SS_n high, in any state (including mid-byte):
  - Go to IDLE, clear bit counter, MISO_OE=0, busy=0.
  - A partial byte is discarded. No register write, no strobe.
- IDLE to CMD, on synchronized SS_n falling:
  - tx_shift <= STATUS, MISO_OE=1, busy=1.
  - MISO = tx_shift[7], so STATUS[7] is valid before the first SCLK rise.
- On each SCLK rising edge (CMD/DATA):
  - rx_shift <= {rx_shift[6:0], MOSI}, bit counter increments.
  - The 8th rise completes a byte; the counter wraps to 0 and the reload flag is set.
- On each SCLK falling edge:
  - If the reload flag is set: tx_shift <= next_byte, then clear the flag.
  - Otherwise: tx_shift <= {tx_shift[6:0], 0}.
- Byte complete in CMD:
  - addr <= byte[7:3], dir <= byte[1] (1 = write). byte[0] and byte[2] are ignored.
  - next_byte = regs[addr] for a read, 0x00 for a write. Go to DATA.
- Byte complete in DATA, write:
  - regs[addr] <= byte.
  - wr_strobe=1 for exactly one Clk, with wr_addr=addr and wr_data=byte.
  - addr <= addr+1 mod 32 (31 wraps to 0). next_byte = 0x00.
- Byte complete in DATA, read:
  - addr <= addr+1 mod 32, next_byte = regs[addr+1 mod 32].
  - MISO therefore streams consecutive registers with wrap.
- Local read port:
  - rd_data <= regs[rd_addr] every Clk, one-cycle latency.
  - If an SPI write hits the same address in the same cycle, rd_data returns the old value and the new value appears one cycle later.
- Reset asserted mid-transaction: everything returns to reset values immediately. Transfers resume only after a fresh SS_n falling edge.

Test Plan:
- Reset, SS_n held high -> MISO_OE=0, busy=0, rd_data=0x00 for rd_addr 0..31.
- STATUS=0xA5; SS_n low; master sends write to reg 3 (cmd 0x1A), then data 0x3C, 0x7E:
  - MISO during the cmd byte reads 0xA5.
  - Two wr_strobe pulses: (3,0x3C) and (4,0x7E).
  - rd_addr=4 gives 0x7E.
- Write regs 30, 31 = 0x11, 0x22 and reg 0 = 0x33 (single transaction starting at reg 30); then read cmd 0xF0 for 3 bytes -> MISO returns 0x11, 0x22, 0x33 (wrap 31 to 0).
- Write cmd 0x12 then 5 bits of data, SS_n high -> no wr_strobe, reg 2 unchanged, MISO_OE=0 within 3 Clk.
- Reset asserted during the 4th bit of a write data byte, then released -> all registers 0x00; next transaction cmd 0x0A, data 0x55 writes reg 1 = 0x55 normally.
- rd_addr=5 while SPI writes 0x99 to reg 5 in the same Clk -> rd_data shows the old value, then 0x99 on the following cycle.

Source files
------------

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a 32x8 register file to an external master.
// The command byte selects a start register and direction; data bytes auto-increment.
module spi_reg_responder #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              SCLK,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic              MISO_OE,
   input  logic [DATA_W-1:0] STATUS,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   localparam int NREG  = 1 << ADDR_W;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t state;

   logic [1:0]        sclk_ff;
   logic [1:0]        ss_ff;
   logic [1:0]        mosi_ff;
   logic              sclk_prev;
   logic              ss_prev;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              ss_fall;

   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] next_byte;
   logic              reload;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_inc;
   logic              dir_wr;
   logic [DATA_W-1:0] rx_byte;
   logic [DATA_W-1:0] regs [NREG];

   // Synchronizers reset to the idle bus levels so reset release never fakes an edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sclk_ff   <= 2'b00;
         ss_ff     <= 2'b11;
         mosi_ff   <= 2'b00;
         sclk_prev <= 1'b0;
         ss_prev   <= 1'b1;
      end else begin
         sclk_ff   <= {sclk_ff[0], SCLK};
         ss_ff     <= {ss_ff[0], SS_n};
         mosi_ff   <= {mosi_ff[0], MOSI};
         sclk_prev <= sclk_ff[1];
         ss_prev   <= ss_ff[1];
      end
   end

   assign sclk_rise = sclk_ff[1] & ~sclk_prev;
   assign sclk_fall = ~sclk_ff[1] & sclk_prev;
   assign ss_fall   = ~ss_ff[1] & ss_prev;
   assign rx_byte   = {rx_shift[DATA_W-2:0], mosi_ff[1]};
   assign addr_inc  = addr + 1'b1;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         next_byte <= '0;
         reload    <= 1'b0;
         addr      <= '0;
         dir_wr    <= 1'b0;
         MISO_OE   <= 1'b0;
         busy      <= 1'b0;
         rd_data   <= '0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         // Read happens before any same-cycle write lands, so it returns the old value.
         rd_data   <= regs[rd_addr];
         wr_strobe <= 1'b0;
         if (ss_ff[1]) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            reload  <= 1'b0;
            MISO_OE <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (ss_fall) begin
                     state    <= ST_CMD;
                     tx_shift <= STATUS;
                     bit_cnt  <= '0;
                     reload   <= 1'b0;
                     MISO_OE  <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
               ST_CMD, ST_DATA: begin
                  if (sclk_rise) begin
                     rx_shift <= rx_byte;
                     bit_cnt  <= bit_cnt + 1'b1;
                     if (bit_cnt == LAST_BIT) begin
                        reload <= 1'b1;
                        if (state == ST_CMD) begin
                           addr      <= rx_byte[DATA_W-1 -: ADDR_W];
                           dir_wr    <= rx_byte[1];
                           next_byte <= rx_byte[1] ? '0 : regs[rx_byte[DATA_W-1 -: ADDR_W]];
                           state     <= ST_DATA;
                        end else if (dir_wr) begin
                           regs[addr] <= rx_byte;
                           wr_strobe  <= 1'b1;
                           wr_addr    <= addr;
                           wr_data    <= rx_byte;
                           addr       <= addr_inc;
                           next_byte  <= '0;
                        end else begin
                           addr      <= addr_inc;
                           next_byte <= regs[addr_inc];
                        end
                     end
                  end else if (sclk_fall) begin
                     if (reload) begin
                        tx_shift <= next_byte;
                        reload   <= 1'b0;
                     end else begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign MISO      = tx_shift[DATA_W-1];
   assign dbg_state = state;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Randomized bench for spi_reg_responder: drives SPI transactions as a master and
// scores MISO bytes and write strobes against a register-file model.
module tb_spi_reg_responder;

   localparam int HALF = 8;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       SCLK;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic       MISO_OE;
   logic [7:0] STATUS;
   logic [4:0] rd_addr;
   logic [7:0] rd_data;
   logic       wr_strobe;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic [1:0] dbg_state;

   spi_reg_responder dut (
      .Clk(Clk), .Reset(Reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
      .MISO(MISO), .MISO_OE(MISO_OE), .STATUS(STATUS), .rd_addr(rd_addr),
      .rd_data(rd_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 Clk = ~Clk;

   int         total = 0;
   int         bad = 0;
   logic [12:0] exp_q[$];
   logic [7:0]  exp_miso_q[$];
   logic [7:0]  model_regs [32];
   logic [7:0]  tx_buf [8];
   logic        hazard_on = 1'b0;
   logic [7:0]  hazard_old = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic spi_bit(input logic b);
      MOSI = b;
      wait_clk(HALF);
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
   endtask

   // One transaction: STATUS first, then nbytes data bytes, then part_bits loose bits.
   task automatic spi_txn(input logic [7:0] status, input logic [7:0] cmd, input int nbytes,
                          input int part_bits, input logic leave_low);
      logic [4:0] a;
      logic       wr;
      logic [7:0] d;
      STATUS = status;
      SS_n = 1'b0;
      wait_clk(HALF);
      check("busy_on", busy, 1);
      check("oe_on", MISO_OE, 1);
      exp_miso_q.push_back(status);
      spi_byte(cmd);
      a  = cmd[7:3];
      wr = cmd[1];
      for (int k = 0; k < nbytes; k++) begin
         if (wr) begin
            d = tx_buf[k];
            exp_miso_q.push_back(8'h00);
            exp_q.push_back({a, d});
            spi_byte(d);
            model_regs[a] = d;
         end else begin
            exp_miso_q.push_back(model_regs[a]);
            spi_byte(8'($urandom_range(0, 255)));
         end
         a = a + 5'd1;
      end
      for (int k = 0; k < part_bits; k++) spi_bit(1'($urandom_range(0, 1)));
      if (!leave_low) begin
         wait_clk(HALF);
         SS_n = 1'b1;
         repeat (3) @(posedge Clk);
         #1;
         check("oe_off_3clk", MISO_OE, 0);
         check("busy_off", busy, 0);
         wait_clk(HALF);
      end
   endtask

   task automatic rd_sweep(input string name);
      for (int a = 0; a < 32; a++) begin
         rd_addr = 5'(a);
         @(posedge Clk);
         @(negedge Clk);
         check(name, rd_data, model_regs[a]);
      end
   endtask

   // MISO monitor: assemble bytes at SCLK rise, drop partial bytes when SS_n rises.
   initial begin : miso_mon
      logic [7:0] sh;
      int         cnt;
      logic [7:0] e;
      sh = '0;
      cnt = 0;
      forever begin
         @(posedge SCLK or posedge SS_n or posedge Reset);
         if (SS_n || Reset) begin
            cnt = 0;
         end else if (SCLK) begin
            sh = {sh[6:0], MISO};
            cnt++;
            if (cnt == 8) begin
               cnt = 0;
               if (exp_miso_q.size() == 0) begin
                  check("miso_unexpected", sh, 9'h100);
               end else begin
                  e = exp_miso_q.pop_front();
                  check("miso_byte", sh, e);
               end
            end
         end
      end
   end

   // Write-strobe monitor, plus the same-cycle local read hazard when armed.
   initial begin : wr_mon
      logic [12:0] e;
      forever begin
         @(negedge Clk);
         if (wr_strobe) begin
            if (exp_q.size() == 0) begin
               check("wr_unexpected", {wr_addr, wr_data}, 14'h2000);
            end else begin
               e = exp_q.pop_front();
               check("wr_strobe", {wr_addr, wr_data}, e);
               if (hazard_on && wr_addr == rd_addr) begin
                  check("rd_same_cycle_old", rd_data, hazard_old);
                  @(negedge Clk);
                  check("rd_next_cycle_new", rd_data, e[7:0]);
               end
            end
         end
      end
   end

   initial begin
      Reset = 1'b1;
      SCLK = 1'b0;
      SS_n = 1'b1;
      MOSI = 1'b0;
      STATUS = 8'h00;
      rd_addr = 5'd0;
      for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
      wait_clk(5);
      check("rst_oe", MISO_OE, 0);
      check("rst_busy", busy, 0);
      check("rst_miso", MISO, 0);
      check("rst_strobe", wr_strobe, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_rd_data", rd_data, 0);
      Reset = 1'b0;
      wait_clk(HALF);
      check("idle_oe", MISO_OE, 0);
      check("idle_busy", busy, 0);
      rd_sweep("rd_after_reset");

      // Write reg 3 and 4 with STATUS 0xA5 shifted out during the command.
      tx_buf[0] = 8'h3C;
      tx_buf[1] = 8'h7E;
      spi_txn(8'hA5, 8'h1A, 2, 0, 1'b0);
      rd_addr = 5'd4;
      @(posedge Clk);
      @(negedge Clk);
      check("rd_reg4", rd_data, 8'h7E);

      // Write 30, 31, 0 then read back across the wrap.
      tx_buf[0] = 8'h11;
      tx_buf[1] = 8'h22;
      tx_buf[2] = 8'h33;
      spi_txn(8'h5A, 8'hF2, 3, 0, 1'b0);
      spi_txn(8'hC3, 8'hF0, 3, 0, 1'b0);

      // Aborted write: 5 bits of data then SS_n high.
      spi_txn(8'h81, 8'h12, 0, 5, 1'b0);
      rd_sweep("rd_after_abort");

      // Same-cycle local read of a register being written.
      tx_buf[0] = 8'h44;
      spi_txn(8'h00, 8'h2A, 1, 0, 1'b0);
      rd_addr = 5'd5;
      hazard_old = 8'h44;
      hazard_on = 1'b1;
      tx_buf[0] = 8'h99;
      spi_txn(8'h00, 8'h2A, 1, 0, 1'b0);
      hazard_on = 1'b0;

      // Reset in the middle of a data byte.
      spi_txn(8'h0F, 8'h0A, 0, 3, 1'b1);
      MOSI = 1'b1;
      wait_clk(HALF / 2);
      Reset = 1'b1;
      wait_clk(3);
      check("midrst_oe", MISO_OE, 0);
      check("midrst_busy", busy, 0);
      SS_n = 1'b1;
      wait_clk(3);
      Reset = 1'b0;
      for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
      wait_clk(HALF);
      rd_sweep("rd_after_midrst");
      tx_buf[0] = 8'h55;
      spi_txn(8'h3C, 8'h0A, 1, 0, 1'b0);

      // Random traffic against the model.
      for (int t = 0; t < 20; t++) begin
         for (int k = 0; k < 8; k++) tx_buf[k] = 8'($urandom_range(0, 255));
         spi_txn(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 $urandom_range(1, 4), 0, 1'b0);
      end
      rd_sweep("rd_final");

      wait_clk(4);
      check("wr_q_drained", exp_q.size(), 0);
      check("miso_q_drained", exp_miso_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
